uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised, buffered UART transmitter: accepts words over a valid/ready handshake into an internal FIFO and serialises them as asynchronous frames with configurable data width, parity and stop bits. It sits between any byte-stream producer (debug console, PS/2 bridge, logger) and the board TX pin. It replaces the single-word, tick-gated transmitter with exact per-frame bit timing and back-to-back frames.

## Interface
- CLK_HZ, 25000000, clk frequency in Hz
- BAUD, 115200, line rate; BAUD_DIV = CLK_HZ/BAUD (truncated), must be ≥ 2
- DATA_BITS, 8, data bits per frame, 5..9
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, 1 or 2
- FIFO_DEPTH, 16, FIFO words, power of 2, ≥ 2

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- tx_valid  in  1  producer has a word on tx_data
- tx_ready  out  1  FIFO can accept a word this cycle
- tx_data  in  DATA_BITS  word to send, LSB first
- uart_tx  out  1  serial line, idle high
- busy  out  1  a frame is on the line
- fifo_level  out  $clog2(FIFO_DEPTH)+1  words held in FIFO (excludes word being shifted)

## Operation
- Accept: the word is written when tx_valid && tx_ready at a rising edge. tx_ready = (fifo_level < FIFO_DEPTH), derived from registered state. No pass-through: when full, a same-cycle pop does not admit a push.
- Frame: start (0), DATA_BITS data bits LSB first, parity bit if PARITY≠0, STOP_BITS stop bits (1).
- Parity: even → XOR of data bits; odd → its inverse. Computed from the popped word, not from live tx_data.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: uart_tx=1, busy=0. FIFO non-empty → pop into shift register, go to START.
  - START → DATA after one bit time.
  - DATA → PARITY (if enabled) or STOP after DATA_BITS bit times.
  - PARITY → STOP after one bit time.
  - STOP: after STOP_BITS bit times, pop and go to START if FIFO non-empty, else IDLE.
- Bit timer: a counter of width $clog2(BAUD_DIV) is loaded with BAUD_DIV-1 on every state/bit advance and decrements to 0. It runs only when busy, so there is no free-running tick and no start-jitter.
- Bit counter: counts data and stop bits; it never wraps past its limit.
- Push and pop in the same cycle: fifo_level unchanged. Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: uart_tx=1, busy=0, tx_ready=1, fifo_level=0, FSM=IDLE, FIFO pointers=0. Reset mid-frame aborts the frame: uart_tx=1 from the next edge, and FIFO contents are discarded.
- Latency when IDLE with empty FIFO: word accepted at edge N; pop and START at edge N+1. uart_tx=0 and busy=1 are registered outputs, both valid after edge N+1.
- Every line bit, including start, parity and stop, lasts exactly BAUD_DIV cycles.
- Frame length = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × BAUD_DIV cycles.
- Back-to-back frames: the next start bit begins on the cycle after the last stop cycle, with zero idle cycles.
- busy falls on the same edge where uart_tx would otherwise have started a new frame, i.e. at the end of the last stop bit when the FIFO is empty.
- fifo_level updates on the edge following a push or pop.

## Test plan
- 8N1, CLK_HZ=16, BAUD=4 (BAUD_DIV=4), send 0x55 → uart_tx 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles; busy high for exactly 40 cycles; uart_tx=0 one cycle after the accept edge.
- DATA_BITS=7, PARITY=2, send 0x41 → parity bit 0. Repeat with PARITY=1 → parity bit 1. Frame is 40 cycles with BAUD_DIV=4.
- FIFO_DEPTH=4, tx_valid held high with words 0x01..0x06 → 5 words accepted (one popped into the shifter), tx_ready low until the first frame completes, frames sent in order with no idle gap, fifo_level peaks at 4.
- DATA_BITS=9, STOP_BITS=2, send 0x1A5 → data bits 1,0,1,0,0,1,0,1,1 followed by two stop bits; frame is 12×BAUD_DIV cycles.
- Reset asserted for 1 cycle in the middle of the DATA state with 2 words queued → uart_tx=1, busy=0, fifo_level=0 next cycle; no further frames; a new push transmits normally.
- Simultaneous push and pop at fifo_level=2 → fifo_level stays 2; a push attempted while full and popping in the same cycle is refused (tx_ready=0).

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: valid/ready write port into a small FIFO, drained
// by a framing FSM that emits start/data/parity/stop bits with exact bit timing.
module uart_tx_fifo #(
    parameter int CLK_HZ     = 25000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic [DATA_BITS-1:0]          tx_data,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int BAUD_DIV = CLK_HZ / BAUD;
    localparam int TW       = $clog2(BAUD_DIV);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int LW       = AW + 1;
    localparam int BW       = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] BIT_LOAD   = TW'(BAUD_DIV - 1);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_DATA  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP  = BW'(STOP_BITS - 1);
    localparam logic          ODD_SEED   = (PARITY == 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_reg;
    logic [AW-1:0]        rd_ptr_reg;
    logic [LW-1:0]        level_reg;
    logic                 push;
    logic                 pop;

    // Transmit engine
    state_t               state_reg;
    logic [TW-1:0]        timer_reg;
    logic [BW-1:0]        bit_cnt_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_reg;
    logic                 bit_done;

    // Readiness depends only on the registered level, so a pop never frees a slot early.
    assign tx_ready   = (level_reg < FULL_LEVEL);
    assign push       = tx_valid && tx_ready;
    assign fifo_level = level_reg;
    assign bit_done   = (timer_reg == '0);

    always_comb begin
        pop = 1'b0;
        if (level_reg != '0) begin
            if (state_reg == ST_IDLE) begin
                pop = 1'b1;
            end else if (state_reg == ST_STOP && bit_done && bit_cnt_reg == LAST_STOP) begin
                pop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

    // The bit timer is reloaded on every line-bit boundary, so each bit is exactly BAUD_DIV cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            uart_tx     <= 1'b1;
            busy        <= 1'b0;
            timer_reg   <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            parity_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    uart_tx <= 1'b1;
                    busy    <= 1'b0;
                    if (pop) begin
                        shift_reg <= mem[rd_ptr_reg];
                        timer_reg <= BIT_LOAD;
                        uart_tx   <= 1'b0;
                        busy      <= 1'b1;
                        state_reg <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_done) begin
                        parity_reg  <= ^shift_reg ^ ODD_SEED;
                        uart_tx     <= shift_reg[0];
                        bit_cnt_reg <= '0;
                        timer_reg   <= BIT_LOAD;
                        state_reg   <= ST_DATA;
                    end else begin
                        timer_reg <= timer_reg - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        timer_reg <= BIT_LOAD;
                        if (bit_cnt_reg == LAST_DATA) begin
                            bit_cnt_reg <= '0;
                            if (PARITY != 0) begin
                                uart_tx   <= parity_reg;
                                state_reg <= ST_PARITY;
                            end else begin
                                uart_tx   <= 1'b1;
                                state_reg <= ST_STOP;
                            end
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            shift_reg   <= shift_reg >> 1;
                            uart_tx     <= shift_reg[1];
                        end
                    end else begin
                        timer_reg <= timer_reg - 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (bit_done) begin
                        uart_tx     <= 1'b1;
                        bit_cnt_reg <= '0;
                        timer_reg   <= BIT_LOAD;
                        state_reg   <= ST_STOP;
                    end else begin
                        timer_reg <= timer_reg - 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_done) begin
                        if (bit_cnt_reg == LAST_STOP) begin
                            // Chain straight into the next start bit when a word is waiting.
                            if (pop) begin
                                shift_reg   <= mem[rd_ptr_reg];
                                timer_reg   <= BIT_LOAD;
                                uart_tx     <= 1'b0;
                                bit_cnt_reg <= '0;
                                state_reg   <= ST_START;
                            end else begin
                                uart_tx     <= 1'b1;
                                busy        <= 1'b0;
                                bit_cnt_reg <= '0;
                                state_reg   <= ST_IDLE;
                            end
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            timer_reg   <= BIT_LOAD;
                        end
                    end else begin
                        timer_reg <= timer_reg - 1'b1;
                    end
                end
                default: begin
                    uart_tx   <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four configurations (8N1, 7E1, 7O1, 9N2) at BAUD_DIV=4,
// with per-instance frame monitors checking against queued expected line patterns.
module tb_uart_tx_fifo;

    localparam int NI = 4;

    function automatic int db_of(input int k);
        case (k)
            1, 2:    return 7;
            3:       return 9;
            default: return 8;
        endcase
    endfunction

    function automatic int par_of(input int k);
        case (k)
            1:       return 2;
            2:       return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int stop_of(input int k);
        return (k == 3) ? 2 : 1;
    endfunction

    function automatic int nb_of(input int k);
        return 1 + db_of(k) + ((par_of(k) != 0) ? 1 : 0) + stop_of(k);
    endfunction

    logic       clk = 1'b0;
    logic       reset;
    logic       valid [NI];
    logic [8:0] data  [NI];
    logic       rdy   [NI];
    logic       line  [NI];
    logic       bsy   [NI];
    logic [2:0] lvl   [NI];

    int vectors     = 0;
    int miscompares = 0;

    // Expected line pattern per frame: bit 0 is the start bit, then data, parity, stop.
    logic [11:0] exp_q [NI][$];

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            localparam int DB = db_of(gi);
            localparam int NB = nb_of(gi);

            uart_tx_fifo #(
                .CLK_HZ    (16),
                .BAUD      (4),
                .DATA_BITS (DB),
                .PARITY    (par_of(gi)),
                .STOP_BITS (stop_of(gi)),
                .FIFO_DEPTH(4)
            ) u_dut (
                .clk       (clk),
                .reset     (reset),
                .tx_valid  (valid[gi]),
                .tx_ready  (rdy[gi]),
                .tx_data   (data[gi][DB-1:0]),
                .uart_tx   (line[gi]),
                .busy      (bsy[gi]),
                .fifo_level(lvl[gi])
            );

            initial begin : monitor
                logic [11:0] cap;
                logic [11:0] req;
                bit          bad;
                bit          aborted;
                forever begin
                    @(negedge clk);
                    if (reset !== 1'b0 || line[gi] !== 1'b0) continue;
                    cap     = '0;
                    bad     = 1'b0;
                    aborted = 1'b0;
                    for (int i = 0; i < NB * 4; i++) begin
                        if (i > 0) @(negedge clk);
                        if (reset !== 1'b0) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (i % 4 == 0) cap[i / 4] = line[gi];
                        else if (line[gi] !== cap[i / 4]) bad = 1'b1;
                        if (bsy[gi] !== 1'b1) bad = 1'b1;
                    end
                    if (!aborted) begin
                        vectors++;
                        if (exp_q[gi].size() == 0) begin
                            miscompares++;
                            $display("FAIL frame[%0d]: got unexpected frame 0x%03h, required no frame", gi, cap);
                        end else begin
                            req = exp_q[gi].pop_front();
                            if (bad || cap !== req) begin
                                miscompares++;
                                $display("FAIL frame[%0d]: got 0x%03h%s, required 0x%03h", gi, cap,
                                         bad ? " with unstable bit or busy low" : "", req);
                            end else begin
                                $display("frame[%0d]: 0x%03h ok", gi, cap);
                            end
                        end
                    end
                end
            end
        end
    endgenerate

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end else begin
            $display("check %s: %0h ok", name, act);
        end
    endtask

    // Presents a word at a negedge, holding it until tx_ready; returns just after the accept edge.
    task automatic send(input int k, input logic [8:0] d, input logic [11:0] f,
                        input bit expect_frame, output int waited);
        waited = 0;
        forever begin
            @(negedge clk);
            valid[k] = 1'b1;
            data[k]  = d;
            if (rdy[k] === 1'b1) break;
            waited++;
            if (waited > 200) begin
                vectors++;
                miscompares++;
                $display("FAIL send[%0d]: tx_ready still low after 200 cycles, required high", k);
                valid[k] = 1'b0;
                return;
            end
        end
        @(posedge clk);
        if (expect_frame) exp_q[k].push_back(f);
    endtask

    task automatic release_valid(input int k);
        @(negedge clk);
        valid[k] = 1'b0;
    endtask

    task automatic count_busy(input int k, output int n);
        int t;
        t = 0;
        while (bsy[k] !== 1'b1 && t < 8) begin
            @(negedge clk);
            t++;
        end
        n = 0;
        while (bsy[k] === 1'b1 && n < 400) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_all_idle();
        int  t;
        bit  idle;
        t = 0;
        forever begin
            @(negedge clk);
            idle = 1'b1;
            for (int k = 0; k < NI; k++) begin
                if (bsy[k] !== 1'b0 || lvl[k] !== 3'd0 || exp_q[k].size() != 0) idle = 1'b0;
            end
            if (idle) break;
            t++;
            if (t > 3000) begin
                vectors++;
                miscompares++;
                $display("FAIL idle wait: design still busy after 3000 cycles, required idle");
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int n;
        int nb;
        int pending;

        reset = 1'b1;
        for (int k = 0; k < NI; k++) begin
            valid[k] = 1'b0;
            data[k]  = '0;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < NI; k++) begin
            check($sformatf("reset uart_tx[%0d]", k), 32'(line[k]), 32'd1);
            check($sformatf("reset busy[%0d]", k), 32'(bsy[k]), 32'd0);
            check($sformatf("reset tx_ready[%0d]", k), 32'(rdy[k]), 32'd1);
            check($sformatf("reset fifo_level[%0d]", k), 32'(lvl[k]), 32'd0);
        end

        // 8N1 0x55: start bit one cycle after accept, 40-cycle busy window
        send(0, 9'h055, 12'h2AA, 1'b1, w);
        release_valid(0);
        check("8N1 line idle at accept+0", 32'(line[0]), 32'd1);
        check("8N1 level after accept", 32'(lvl[0]), 32'd1);
        @(negedge clk);
        check("8N1 start bit at accept+1", 32'(line[0]), 32'd0);
        check("8N1 busy at accept+1", 32'(bsy[0]), 32'd1);
        check("8N1 level after pop", 32'(lvl[0]), 32'd0);
        count_busy(0, n);
        check("8N1 busy cycles", 32'(n), 32'd40);

        // Parity configurations and the 9-bit, two-stop-bit frame
        send(1, 9'h041, 12'h282, 1'b1, w);
        release_valid(1);
        count_busy(1, n);
        check("7E1 busy cycles", 32'(n), 32'd40);
        send(2, 9'h041, 12'h382, 1'b1, w);
        release_valid(2);
        count_busy(2, n);
        check("7O1 busy cycles", 32'(n), 32'd40);
        send(1, 9'h007, 12'h30E, 1'b1, w);
        release_valid(1);
        send(2, 9'h007, 12'h20E, 1'b1, w);
        release_valid(2);
        send(3, 9'h1A5, 12'hF4A, 1'b1, w);
        release_valid(3);
        count_busy(3, n);
        check("9N2 busy cycles", 32'(n), 32'd48);
        send(3, 9'h0FF, 12'hDFE, 1'b1, w);
        release_valid(3);
        wait_all_idle();

        // Depth-4 FIFO with tx_valid held high across six words
        for (int i = 1; i <= 5; i++) begin
            send(0, 9'(i), 12'h200 | 12'(i << 1), 1'b1, w);
            check($sformatf("fifo word %0d accept wait", i), 32'(w), 32'd0);
        end
        @(negedge clk);
        check("fifo peak level", 32'(lvl[0]), 32'd4);
        check("fifo full tx_ready", 32'(rdy[0]), 32'd0);
        send(0, 9'h006, 12'h20C, 1'b1, w);
        check("fifo word 6 wait cycles", 32'(w), 32'd36);
        release_valid(0);
        check("fifo level after refill", 32'(lvl[0]), 32'd4);
        count_busy(0, n);
        check("fifo back-to-back busy run", 32'(n), 32'd199);
        wait_all_idle();

        // Push lands on the same edge as the pop, with two words queued
        send(0, 9'h011, 12'h222, 1'b1, w);
        send(0, 9'h022, 12'h244, 1'b1, w);
        send(0, 9'h033, 12'h266, 1'b1, w);
        release_valid(0);
        repeat (37) @(negedge clk);
        check("level before push+pop", 32'(lvl[0]), 32'd2);
        send(0, 9'h044, 12'h288, 1'b1, w);
        release_valid(0);
        check("level after push+pop", 32'(lvl[0]), 32'd2);
        check("busy across push+pop", 32'(bsy[0]), 32'd1);
        wait_all_idle();

        // Reset in the middle of the data bits with two words queued
        send(0, 9'h0AA, 12'h000, 1'b0, w);
        send(0, 9'h0BB, 12'h000, 1'b0, w);
        send(0, 9'h0CC, 12'h000, 1'b0, w);
        release_valid(0);
        repeat (10) @(negedge clk);
        check("pre-reset level", 32'(lvl[0]), 32'd2);
        check("pre-reset busy", 32'(bsy[0]), 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("post-reset uart_tx", 32'(line[0]), 32'd1);
        check("post-reset busy", 32'(bsy[0]), 32'd0);
        check("post-reset level", 32'(lvl[0]), 32'd0);
        check("post-reset tx_ready", 32'(rdy[0]), 32'd1);
        nb = 0;
        repeat (60) begin
            @(negedge clk);
            if (bsy[0] !== 1'b0) nb++;
        end
        check("no frames after reset", 32'(nb), 32'd0);
        send(0, 9'h05A, 12'h2B4, 1'b1, w);
        release_valid(0);
        count_busy(0, n);
        check("post-reset frame cycles", 32'(n), 32'd40);

        wait_all_idle();
        pending = 0;
        for (int k = 0; k < NI; k++) pending += exp_q[k].size();
        check("frames still expected", 32'(pending), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
